// File: rtl/lcd_ram_arbiter_if.sv
// Request bus between one requester (CPU or LCD refresh) and the LCD RAM arbiter.
// The requester holds the master modport; the arbiter holds the slave modport.
interface lcd_ram_arbiter_if;
   logic [10:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/lcd_ram_arbiter.sv
// Two-port arbiter in front of a single-port 2048x32 RAM: port 0 is the CPU, port 1 the
// LCD refresh engine. Round-robin with a hold limit, or fixed priority to port 0.
module lcd_ram_arbiter #(
   parameter int unsigned MAX_HOLD   = 4,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   lcd_ram_arbiter_if.slave s0,
   lcd_ram_arbiter_if.slave s1,
   output logic [10:0]      ram_address,
   output logic             ram_chipselect,
   output logic             ram_write,
   output logic [3:0]       ram_byteenable,
   output logic [31:0]      ram_writedata,
   output logic             ram_clken,
   input  logic [31:0]      ram_readdata
);

   localparam logic [3:0] HoldLimit = 4'(MAX_HOLD);

   logic [1:0] req;
   logic [1:0] grant;
   logic       granted;
   logic       grant_port;
   logic       granted_write;
   logic       keep_owner;

   logic       last_grant_q, last_grant_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic [1:0] prev_req_q, prev_req_d;
   logic       rd_pending_q, rd_pending_d;
   logic       rd_owner_q, rd_owner_d;

   // Requests are masked while in reset so every output rests at its idle value.
   assign req[0] = reset_n & (s0.read | s0.write);
   assign req[1] = reset_n & (s1.read | s1.write);

   // The current owner keeps the RAM under contention until its burst hits the hold limit.
   assign keep_owner = (hold_cnt_q < HoldLimit) && prev_req_q[last_grant_q];

   always_comb begin : arbitrate
      grant = 2'b00;
      case (req)
         2'b01: grant = 2'b01;
         2'b10: grant = 2'b10;
         2'b11: begin
            if (FIXED_PRIO != 0) begin
               grant = 2'b01;
            end else if (keep_owner) begin
               grant = last_grant_q ? 2'b10 : 2'b01;
            end else begin
               grant = last_grant_q ? 2'b01 : 2'b10;
            end
         end
         default: grant = 2'b00;
      endcase
   end

   assign granted       = |grant;
   assign grant_port    = grant[1];
   assign granted_write = grant_port ? s1.write : s0.write;

   always_ff @(posedge clk or negedge reset_n) begin : state_reg
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         hold_cnt_q   <= 4'd0;
         prev_req_q   <= 2'b00;
         rd_pending_q <= 1'b0;
         rd_owner_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         hold_cnt_q   <= hold_cnt_d;
         prev_req_q   <= prev_req_d;
         rd_pending_q <= rd_pending_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   always_comb begin : next_state
      last_grant_d = last_grant_q;
      hold_cnt_d   = 4'd0;
      prev_req_d   = req;
      rd_pending_d = granted & ~granted_write;
      rd_owner_d   = grant_port;
      if (granted) begin
         last_grant_d = grant_port;
         if (grant_port == last_grant_q) begin
            hold_cnt_d = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
         end else begin
            hold_cnt_d = 4'd1;
         end
      end
   end

   always_comb begin : outputs
      s0.waitrequest   = ~grant[0];
      s1.waitrequest   = ~grant[1];
      s0.readdatavalid = rd_pending_q & ~rd_owner_q;
      s1.readdatavalid = rd_pending_q & rd_owner_q;
      // Both ports see the RAM data; each qualifies it with its own readdatavalid.
      s0.readdata      = ram_readdata;
      s1.readdata      = ram_readdata;
      ram_chipselect   = granted;
      ram_write        = granted & granted_write;
      ram_clken        = reset_n;
      ram_address      = 11'd0;
      ram_byteenable   = 4'd0;
      ram_writedata    = 32'd0;
      unique case (grant)
         2'b01: begin
            ram_address    = s0.address;
            ram_byteenable = s0.byteenable;
            ram_writedata  = s0.writedata;
         end
         2'b10: begin
            ram_address    = s1.address;
            ram_byteenable = s1.byteenable;
            ram_writedata  = s1.writedata;
         end
         default: ;
      endcase
   end

   a_one_grant: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));
   a_grant_has_req: assert property (@(posedge clk) disable iff (!reset_n)
      (grant & ~req) == 2'b00);
   a_one_valid: assert property (@(posedge clk) disable iff (!reset_n)
      !(s0.readdatavalid && s1.readdatavalid));

   if (FIXED_PRIO == 0) begin : g_rr_check
      a_hold_limit: assert property (@(posedge clk) disable iff (!reset_n)
         (req == 2'b11 && hold_cnt_q >= HoldLimit) |-> grant[last_grant_q] == 1'b0);
   end

endmodule

// File: tb/tb_lcd_ram_arbiter.sv
// Directed, table-driven bench for lcd_ram_arbiter with a behavioural 2048x32 RAM model.
module tb_lcd_ram_arbiter;

   typedef struct packed {
      logic        r0, w0;
      logic [10:0] a0;
      logic [3:0]  be0;
      logic [31:0] d0;
      logic        r1, w1;
      logic [10:0] a1;
      logic [3:0]  be1;
      logic [31:0] d1;
      logic        eg0, eg1, ev0, ev1, ecs, ewe;
      logic [3:0]  ebe;
      logic [10:0] eaddr;
      logic [31:0] ewd;
      logic [31:0] erd;
   } vec_t;

   localparam int NV = 17;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic preload = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   lcd_ram_arbiter_if m0 ();
   lcd_ram_arbiter_if m1 ();
   lcd_ram_arbiter_if f0 ();
   lcd_ram_arbiter_if f1 ();

   logic [10:0] ram_address, f_address;
   logic        ram_chipselect, ram_write, ram_clken, f_cs, f_we, f_clken;
   logic [3:0]  ram_byteenable, f_be;
   logic [31:0] ram_writedata, f_wd, ram_rdata;
   logic [31:0] mem [2048];
   vec_t        vecs [NV];

   always #5 clk = ~clk;

   lcd_ram_arbiter #(.MAX_HOLD(4), .FIXED_PRIO(0)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .s0             (m0),
      .s1             (m1),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_byteenable (ram_byteenable),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_rdata)
   );

   // Fixed-priority instance shadows the same requester stimulus.
   lcd_ram_arbiter #(.MAX_HOLD(4), .FIXED_PRIO(1)) dut_fp (
      .clk            (clk),
      .reset_n        (reset_n),
      .s0             (f0),
      .s1             (f1),
      .ram_address    (f_address),
      .ram_chipselect (f_cs),
      .ram_write      (f_we),
      .ram_byteenable (f_be),
      .ram_writedata  (f_wd),
      .ram_clken      (f_clken),
      .ram_readdata   (32'h0)
   );

   assign f0.address = m0.address;
   assign f0.read = m0.read;
   assign f0.write = m0.write;
   assign f0.byteenable = m0.byteenable;
   assign f0.writedata = m0.writedata;
   assign f1.address = m1.address;
   assign f1.read = m1.read;
   assign f1.write = m1.write;
   assign f1.byteenable = m1.byteenable;
   assign f1.writedata = m1.writedata;

   always @(posedge clk) begin
      if (preload) begin
         mem[11'h005] <= 32'hDEADBEEF;
         mem[11'h7FF] <= 32'h11223344;
      end else if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++) begin
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
         end else begin
            ram_rdata <= mem[ram_address];
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      m0.read = v.r0;  m0.write = v.w0;  m0.address = v.a0;
      m0.byteenable = v.be0;  m0.writedata = v.d0;
      m1.read = v.r1;  m1.write = v.w1;  m1.address = v.a1;
      m1.byteenable = v.be1;  m1.writedata = v.d1;
   endtask

   task automatic drive_idle();
      vec_t z;
      z = '0;
      drive(z);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {m0.waitrequest, m1.waitrequest, m0.readdatavalid, m1.readdatavalid,
                   ram_chipselect, ram_write, ram_clken, f1.waitrequest, f0.readdatavalid},
            9'b11_00_000_1_0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{default: '0};
      vecs[1]  = '{r0: 1'b1, a0: 11'h005, be0: 4'hF,
                   eg0: 1'b1, ecs: 1'b1, ebe: 4'hF, eaddr: 11'h005, default: '0};
      vecs[2]  = '{ev0: 1'b1, erd: 32'hDEADBEEF, default: '0};
      vecs[3]  = '{w1: 1'b1, a1: 11'h7FF, be1: 4'h3, d1: 32'hAABBCCDD, eg1: 1'b1, ecs: 1'b1,
                   ewe: 1'b1, ebe: 4'h3, eaddr: 11'h7FF, ewd: 32'hAABBCCDD, default: '0};
      vecs[4]  = '{r1: 1'b1, a1: 11'h7FF, be1: 4'hF,
                   eg1: 1'b1, ecs: 1'b1, ebe: 4'hF, eaddr: 11'h7FF, default: '0};
      vecs[5]  = '{ev1: 1'b1, erd: 32'h1122CCDD, default: '0};
      vecs[6]  = '{r0: 1'b1, w0: 1'b1, a0: 11'h010, be0: 4'hF, d0: 32'h42, eg0: 1'b1, ecs: 1'b1,
                   ewe: 1'b1, ebe: 4'hF, eaddr: 11'h010, ewd: 32'h42, default: '0};
      vecs[7]  = '{r0: 1'b1, a0: 11'h010, be0: 4'hF,
                   eg0: 1'b1, ecs: 1'b1, ebe: 4'hF, eaddr: 11'h010, default: '0};
      vecs[8]  = '{ev0: 1'b1, erd: 32'h42, default: '0};
      vecs[9]  = '{r0: 1'b1, a0: 11'h005, be0: 4'hF, r1: 1'b1, a1: 11'h7FF, be1: 4'hF,
                   eg1: 1'b1, ecs: 1'b1, ebe: 4'hF, eaddr: 11'h7FF, default: '0};
      vecs[10] = '{r0: 1'b1, a0: 11'h005, be0: 4'hF, eg0: 1'b1, ecs: 1'b1, ebe: 4'hF,
                   eaddr: 11'h005, ev1: 1'b1, erd: 32'h1122CCDD, default: '0};
      vecs[11] = '{r1: 1'b1, a1: 11'h7FF, be1: 4'hF, eg1: 1'b1, ecs: 1'b1, ebe: 4'hF,
                   eaddr: 11'h7FF, ev0: 1'b1, erd: 32'hDEADBEEF, default: '0};
      vecs[12] = '{a0: 11'h123, be0: 4'hF, d0: 32'hFFFFFFFF,
                   ev1: 1'b1, erd: 32'h1122CCDD, default: '0};
      vecs[13] = '{w0: 1'b1, a0: 11'h000, be0: 4'hF, d0: 32'h12345678, r1: 1'b1, a1: 11'h000,
                   be1: 4'hF, eg0: 1'b1, ecs: 1'b1, ewe: 1'b1, ebe: 4'hF, eaddr: 11'h000,
                   ewd: 32'h12345678, default: '0};
      vecs[14] = '{r1: 1'b1, a1: 11'h000, be1: 4'hF,
                   eg1: 1'b1, ecs: 1'b1, ebe: 4'hF, eaddr: 11'h000, default: '0};
      vecs[15] = '{ev1: 1'b1, erd: 32'h12345678, default: '0};
      vecs[16] = '{default: '0};

      // Requests held during reset must not leak through.
      drive_idle();
      m0.read = 1'b1;  m0.address = 11'h155;  m1.write = 1'b1;
      @(negedge clk);
      #1;
      check_reset_outputs("reset_state");
      check("reset_addr", ram_address, 11'h0);
      @(negedge clk);
      reset_n = 1'b1;
      preload = 1'b0;
      drive_idle();

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d_ctrl", i),
               {~m0.waitrequest, ~m1.waitrequest, m0.readdatavalid, m1.readdatavalid,
                ram_chipselect, ram_write, ram_byteenable, ram_address, ram_clken},
               {vecs[i].eg0, vecs[i].eg1, vecs[i].ev0, vecs[i].ev1, vecs[i].ecs, vecs[i].ewe,
                vecs[i].ebe, vecs[i].eaddr, 1'b1});
         check($sformatf("vec%0d_wdata", i), ram_writedata, vecs[i].ewd);
         if (vecs[i].ev0 || vecs[i].ev1) begin
            check($sformatf("vec%0d_rdata", i), {m0.readdata, m1.readdata},
                  {vecs[i].erd, vecs[i].erd});
         end
      end

      // Continuous contention from the first cycle after reset.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         int eg;
         int ep;
         @(negedge clk);
         m0.read = 1'b1;  m0.address = 11'h005;  m0.byteenable = 4'hF;
         m1.read = 1'b1;  m1.address = 11'h7FF;  m1.byteenable = 4'hF;
         #1;
         eg = (i / 4) % 2;
         check($sformatf("rr%0d_grant", i), {~m0.waitrequest, ~m1.waitrequest, ram_address},
               {(eg == 0), (eg == 1), (eg == 1) ? 11'h7FF : 11'h005});
         if (i > 0) begin
            ep = ((i - 1) / 4) % 2;
            check($sformatf("rr%0d_valid", i),
                  {m0.readdatavalid, m1.readdatavalid, m0.readdata},
                  {(ep == 0), (ep == 1), (ep == 1) ? 32'h1122CCDD : 32'hDEADBEEF});
         end
         check($sformatf("fp%0d_grant", i),
               {~f0.waitrequest, ~f1.waitrequest, f_cs, f_we, f_address, f_be, f_wd, f_clken,
                f0.readdatavalid, f1.readdatavalid, f0.readdata, f1.readdata},
               {1'b1, 1'b0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0, 1'b1, (i > 0), 1'b0, 64'h0});
      end
      @(negedge clk);
      m0.read = 1'b0;
      #1;
      check("fp_s1_after_drop", {~f0.waitrequest, ~f1.waitrequest, ~m0.waitrequest,
                                 ~m1.waitrequest}, 4'b0101);
      check("rr_tail_valid0", {m0.readdatavalid, m1.readdatavalid, m0.readdata},
            {2'b10, 32'hDEADBEEF});
      @(negedge clk);
      drive_idle();
      #1;
      check("rr_tail_valid1", {m0.readdatavalid, m1.readdatavalid, m1.readdata,
                               f0.readdatavalid, f1.readdatavalid}, {2'b01, 32'h1122CCDD, 2'b01});

      // Reset lands between read acceptance and its data cycle.
      @(negedge clk);
      m0.read = 1'b1;  m0.address = 11'h005;  m0.byteenable = 4'hF;
      #1;
      check("midrd_accept", {m0.waitrequest, ram_chipselect}, 2'b01);
      #2;
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check_reset_outputs($sformatf("midrd_reset%0d", k));
      end
      @(negedge clk);
      drive_idle();
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("midrd_novalid%0d", k),
               {m0.readdatavalid, m1.readdatavalid, ram_clken}, 3'b001);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
